sub_byte_seq: RTL

//  Forward AES SubBytes for the 64-bit datapath: counterpart of the inverse-substitution stage on the encrypt side.

---
 rtl/sub_byte_pkg.sv | 56 +++++
 rtl/sbox_lut.sv | 19 +
 rtl/sub_byte_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/sub_byte_pkg.sv
// rtl/sub_byte_pkg.sv - shared types, step count and S-box tables for sub_byte_seq
// The inverse table exists only when SUB_BYTE_INV_MODE_EN is defined.
package sub_byte_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nstep(input int lanes);
    return 8 / lanes;
  endfunction

  // Index 0 is the leftmost entry, so SBOX[x] reads straight from the usual 16x16 table.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUB_BYTE_INV_MODE_EN
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
`endif

endpackage

// File: rtl/sbox_lut.sv
// rtl/sbox_lut.sv - combinational byte substitution lane
// Forward only by default; SUB_BYTE_INV_MODE_EN adds the inv select pin.
module sbox_lut
  import sub_byte_pkg::*;
(
`ifdef SUB_BYTE_INV_MODE_EN
  input  logic       inv,
`endif
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

`ifdef SUB_BYTE_INV_MODE_EN
  assign out_byte = inv ? INV_SBOX[in_byte] : SBOX[in_byte];
`else
  assign out_byte = SBOX[in_byte];
`endif

endmodule

// File: rtl/sub_byte_seq.sv
// rtl/sub_byte_seq.sv - sequential AES SubBytes over a 64-bit word, LANES bytes per cycle
// SUB_BYTE_INV_MODE_EN adds inv_sel to run the inverse S-box for the decrypt path.
module sub_byte_seq
  import sub_byte_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
`ifdef SUB_BYTE_INV_MODE_EN
  input  logic        inv_sel,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        busy
);

  localparam int         NSTEP    = nstep(LANES);
  localparam logic [2:0] LAST_CNT = 3'(NSTEP - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("sub_byte_seq: LANES must be 1, 2, 4 or 8");
  end

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;
  logic [2:0]  lane_pos [LANES];
  logic [7:0]  lane_in  [LANES];
  logic [7:0]  lane_out [LANES];
`ifdef SUB_BYTE_INV_MODE_EN
  logic        inv_q, inv_d;
`endif

  // Lane l of step cnt covers byte 7 - cnt*LANES - l, walking from the MSB down.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_pos[l] = 3'(7 - LANES * int'(cnt_q) - l);
    assign lane_in[l]  = work_q[{lane_pos[l], 3'b000} +: 8];

    sbox_lut u_sbox (
`ifdef SUB_BYTE_INV_MODE_EN
      .inv      (inv_q),
`endif
      .in_byte  (lane_in[l]),
      .out_byte (lane_out[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef SUB_BYTE_INV_MODE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef SUB_BYTE_INV_MODE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef SUB_BYTE_INV_MODE_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = ST_BUSY;
`ifdef SUB_BYTE_INV_MODE_EN
          inv_d   = inv_sel;
`endif
        end
      end
      ST_BUSY: begin
        for (int l = 0; l < LANES; l++) begin
          work_d[{lane_pos[l], 3'b000} +: 8] = lane_out[l];
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // in_ready must read low for the whole time reset is held, not only after the state clears.
  assign in_ready  = (state_q == ST_IDLE) && rst_n;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign out_data  = work_q;

endmodule
